vga_timing_gen: RTL and testbench

//  Source end of vga_if: generates hcount/vcount, hsync/vsync, hblnk/vblnk for every pixel clock and

---
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 tb/tb_vga_timing_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing source. Produces the hcount/vcount, sync and
//               blank signals plus a frame_start strobe. Optional macro
//               VGA_TIMING_PIXEL_DIV2_EN advances one pixel every second clock.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        frame_start,
  output logic [10:0] vcount,
  output logic [10:0] hcount,
  output logic        vsync,
  output logic        hsync,
  output logic        vblnk,
  output logic        hblnk,
  output logic [11:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] C_H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_H_BLANK    = 11'(H_ACTIVE);
  localparam logic [10:0] C_H_HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] C_H_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] C_V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] C_V_BLANK    = 11'(V_ACTIVE);
  localparam logic [10:0] C_V_VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] C_V_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048 ||
        H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
      $error("vga_timing_gen: totals must be <= 2048 and porch/sync widths non-zero");
    end
  endgenerate

  logic        adv;
  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap, v_wrap;
  logic [10:0] h_nxt, v_nxt;

`ifdef VGA_TIMING_PIXEL_DIV2_EN
  // Phase flop: advance on the second of every two enabled clocks.
  logic tick_q, tick_d;

  always_comb begin
    tick_d = en ? ~tick_q : tick_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end

  assign adv = en & tick_q;
`else
  assign adv = en;
`endif

  always_comb begin
    h_wrap = (hcount_q == C_H_LAST);
    v_wrap = (vcount_q == C_V_LAST);
    h_nxt  = h_wrap ? 11'd0 : hcount_q + 11'd1;
    v_nxt  = h_wrap ? (v_wrap ? 11'd0 : vcount_q + 11'd1) : vcount_q;

    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblnk_d       = hblnk_q;
    vblnk_d       = vblnk_q;
    frame_start_d = 1'b0;

    // Decode from the next counts so every registered output names one pixel.
    if (adv) begin
      hcount_d      = h_nxt;
      vcount_d      = v_nxt;
      hblnk_d       = (h_nxt >= C_H_BLANK);
      vblnk_d       = (v_nxt >= C_V_BLANK);
      hsync_d       = (h_nxt >= C_H_HS_START && h_nxt < C_H_HS_END) ? HS_POL : ~HS_POL;
      vsync_d       = (v_nxt >= C_V_VS_START && v_nxt < C_V_VS_END) ? VS_POL : ~VS_POL;
      frame_start_d = h_wrap & v_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign frame_start = frame_start_q;
  assign rgb         = 12'h000;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen; a default-timing instance
//               and a small-frame instance with inverted sync polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIXEL_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
    logic [11:0] rgb;
  } out_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } tim_t;

  typedef struct {
    int h, v;
    bit tick;
    bit fs;
  } mdl_t;

  typedef struct {
    bit en;
    int n;
    int eh_a, ev_a, eh_b, ev_b;
  } seg_t;

  logic        clk, rst_n, en;
  logic        fs_a, hs_a, vs_a, hb_a, vb_a;
  logic        fs_b, hs_b, vs_b, hb_b, vb_b;
  logic [10:0] hc_a, vc_a, hc_b, vc_b;
  logic [11:0] rgb_a, rgb_b;
  out_t        act_a, act_b;

  int   checks = 0;
  int   errors = 0;
  int   fs_cnt_b = 0;
  tim_t ta, tb;
  mdl_t ma, mb;
  out_t q_a[$];
  out_t q_b[$];
  seg_t segs[5];

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_start(fs_a),
    .vcount(vc_a), .hcount(hc_a), .vsync(vs_a), .hsync(hs_a),
    .vblnk(vb_a), .hblnk(hb_a), .rgb(rgb_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_start(fs_b),
    .vcount(vc_b), .hcount(hc_b), .vsync(vs_b), .hsync(hs_b),
    .vblnk(vb_b), .hblnk(hb_b), .rgb(rgb_b)
  );

  assign act_a = {hc_a, vc_a, hs_a, vs_a, hb_a, vb_a, fs_a, rgb_a};
  assign act_b = {hc_b, vc_b, hs_b, vs_b, hb_b, vb_b, fs_b, rgb_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mstep(tim_t t, mdl_t m, bit e);
    mdl_t r;
    bit   adv;
    int   ht, vt;
    r  = m;
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    r.fs = 1'b0;
`ifdef VGA_TIMING_PIXEL_DIV2_EN
    adv = e && m.tick;
    if (e) r.tick = !m.tick;
`else
    adv = e;
`endif
    if (adv) begin
      if (m.h == ht - 1) begin
        r.h = 0;
        if (m.v == vt - 1) begin
          r.v  = 0;
          r.fs = 1'b1;
        end else begin
          r.v = m.v + 1;
        end
      end else begin
        r.h = m.h + 1;
      end
    end
    return r;
  endfunction

  function automatic out_t mexp(tim_t t, mdl_t m);
    out_t o;
    o.h   = 11'(m.h);
    o.v   = 11'(m.v);
    o.hb  = (m.h >= t.ha);
    o.vb  = (m.v >= t.va);
    o.hs  = (m.h >= t.ha + t.hf && m.h < t.ha + t.hf + t.hs) ? t.hp : !t.hp;
    o.vs  = (m.v >= t.va + t.vf && m.v < t.va + t.vf + t.vs) ? t.vp : !t.vp;
    o.fs  = m.fs;
    o.rgb = 12'h000;
    return o;
  endfunction

  task automatic check(string name, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b rgb=%h, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b rgb=%h",
               name, $time, act.h, act.v, act.hs, act.vs, act.hb, act.vb, act.fs, act.rgb,
               exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.fs, exp.rgb);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Entered at a negedge; expectations are queued as the input is applied.
  task automatic run_cycle();
    ma = mstep(ta, ma, en);
    mb = mstep(tb, mb, en);
    q_a.push_back(mexp(ta, ma));
    q_b.push_back(mexp(tb, mb));
    @(posedge clk);
    #1;
    check("sb_a", act_a, q_a.pop_front());
    check("sb_b", act_b, q_b.pop_front());
    if (fs_b) fs_cnt_b++;
    @(negedge clk);
  endtask

  task automatic async_reset(string name);
    #2 rst_n = 1'b0;
    #1;
    ma = '{0, 0, 1'b0, 1'b0};
    mb = '{0, 0, 1'b0, 1'b0};
    check({name, "_a"}, act_a, mexp(ta, ma));
    check({name, "_b"}, act_b, mexp(tb, mb));
    @(posedge clk);
    #1;
    check({name, "_hold_a"}, act_a, mexp(ta, ma));
    check({name, "_hold_b"}, act_b, mexp(tb, mb));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ta = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
    tb = '{16, 4, 8, 4, 10, 1, 2, 3, 1'b0, 1'b0};
    // {en, pixels, end h/v of default instance, end h/v of small instance}
    segs[0] = '{1'b1, 1056,   0, 1,  0, 1};
    segs[1] = '{1'b1,  500, 500, 1, 20, 0};
    segs[2] = '{1'b0,   10, 500, 1, 20, 0};
    segs[3] = '{1'b1,    1, 501, 1, 21, 0};
    segs[4] = '{1'b1,  555,   0, 2,  0, 2};

    rst_n = 1'b0;
    en    = 1'b0;
    ma    = '{0, 0, 1'b0, 1'b0};
    mb    = '{0, 0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    check("reset_a", act_a, {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000});
    check("reset_b", act_b, {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000});
    rst_n = 1'b1;

    // Frozen at (0,0) must not strobe frame_start.
    repeat (5) run_cycle();

    for (int i = 0; i < 5; i++) begin
      en = segs[i].en;
      repeat (segs[i].en ? segs[i].n * DIV : segs[i].n) run_cycle();
      check_int($sformatf("seg%0d_h_a", i), int'(hc_a), segs[i].eh_a);
      check_int($sformatf("seg%0d_v_a", i), int'(vc_a), segs[i].ev_a);
      check_int($sformatf("seg%0d_h_b", i), int'(hc_b), segs[i].eh_b);
      check_int($sformatf("seg%0d_v_b", i), int'(vc_b), segs[i].ev_b);
    end
    check_int("frame_starts_b_4", fs_cnt_b, 4);

    // Run the small frame to its wrap, then freeze right after the strobe.
    en = 1'b1;
    repeat (448 * DIV) run_cycle();
    check_int("frame_starts_b_5", fs_cnt_b, 5);
    check_int("wrap_h_b", int'(hc_b), 0);
    check_int("wrap_v_b", int'(vc_b), 0);
    en = 1'b0;
    repeat (5) run_cycle();
    check_int("frozen_no_fs_b", fs_cnt_b, 5);

    // Mid-frame asynchronous reset, then restart from (1,0).
    en = 1'b1;
    repeat (300 * DIV) run_cycle();
    check_int("mid_h_a", int'(hc_a), 748);
    check_int("mid_v_b", int'(vc_b), 9);
    async_reset("async_rst");
    repeat (3 * DIV) run_cycle();
    check_int("restart_h_a", int'(hc_a), 3);
    check_int("restart_v_a", int'(vc_a), 0);
    check_int("frame_starts_b_end", fs_cnt_b, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
